// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential RV64M multiplier: op codes, FSM states,
// widths and the final result selection.
package mul_seq_pkg;

  localparam int XLEN = 64;
  localparam int PW   = 2 * XLEN;
  localparam int CW   = 7;

  localparam logic [3:0] MUL_OP_MUL    = 4'd0;
  localparam logic [3:0] MUL_OP_MULH   = 4'd1;
  localparam logic [3:0] MUL_OP_MULHSU = 4'd2;
  localparam logic [3:0] MUL_OP_MULHU  = 4'd3;
  localparam logic [3:0] MUL_OP_MULW   = 4'd4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic [XLEN-1:0] select_result(input logic [3:0] op,
                                                    input logic [PW-1:0] p);
    case (op)
      MUL_OP_MUL:                             return p[XLEN-1:0];
      MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: return p[PW-1:XLEN];
      MUL_OP_MULW:                            return {{32{p[31]}}, p[31:0]};
      default:                                return '0;
    endcase
  endfunction

endpackage

// File: rtl/mul_seq_absneg.sv
// Combinational operand magnitude/sign extraction and 128-bit conditional negate
// used around the unsigned shift-add core of mul_seq.
module mul_seq_absneg
  import mul_seq_pkg::*;
(
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [3:0]      control,
  output logic [XLEN-1:0] mag1,
  output logic [XLEN-1:0] mag2,
  output logic            neg,
  input  logic [PW-1:0]   acc,
  input  logic            negate,
  output logic [PW-1:0]   prod
);

  logic            signed1;
  logic            signed2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            sign1;
  logic            sign2;

  assign signed1 = control inside {MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULW};
  assign signed2 = control inside {MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULW};

  // MULW works on the sign-extended low words so the same 64-bit negate applies.
  assign op1 = (control == MUL_OP_MULW) ? {{32{src1[31]}}, src1[31:0]} : src1;
  assign op2 = (control == MUL_OP_MULW) ? {{32{src2[31]}}, src2[31:0]} : src2;

  assign sign1 = signed1 & op1[XLEN-1];
  assign sign2 = signed2 & op2[XLEN-1];

  // The most-negative value negates to itself, which read unsigned is 2^63.
  assign mag1 = sign1 ? -op1 : op1;
  assign mag2 = sign2 ? -op2 : op2;
  assign neg  = sign1 ^ sign2;

  assign prod = negate ? -acc : acc;

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW) using a radix-2
// shift-add datapath on operand magnitudes with valid/ready handshakes and flush.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [3:0]      control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_out
);

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_nxt;
  logic [XLEN-1:0] mplier;
  logic [CW-1:0]   count;
  logic [3:0]      op;
  logic            neg;

  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            neg_in;
  logic [PW-1:0]   prod;

  // The negate sees the accumulator including this cycle's add, so the
  // finalised product is ready on the same edge that enters DONE.
  mul_seq_absneg u_absneg (
    .src1    (src1),
    .src2    (src2),
    .control (control),
    .mag1    (mag1),
    .mag2    (mag2),
    .neg     (neg_in),
    .acc     (acc_nxt),
    .negate  (neg),
    .prod    (prod)
  );

  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (count == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mcand      <= '0;
      acc        <= '0;
      mplier     <= '0;
      count      <= '0;
      op         <= '0;
      neg        <= 1'b0;
      result_out <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        result_out <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              mcand  <= {{XLEN{1'b0}}, mag1};
              mplier <= mag2;
              neg    <= neg_in;
              op     <= control;
              acc    <= '0;
              count  <= (control == MUL_OP_MULW) ? CW'(32) : CW'(64);
            end
          end
          BUSY: begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
            if (count == CW'(1)) result_out <= select_result(op, prod);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: scoreboarded op results, latency,
// output hold under backpressure, flush and mid-operation reset.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src1;
  logic [63:0] src2;
  logic [3:0]  control;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result_out;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mul_seq dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src1       (src1),
    .src2       (src2),
    .control    (control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out)
  );

  // Reference products from plain 128-bit modular multiplication.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  w;
    case (op)
      4'd0: return a * b;
      4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      4'd2: begin p = {{64{a[63]}}, a} * {64'b0, b};       return p[127:64]; end
      4'd3: begin p = {64'b0, a} * {64'b0, b};             return p[127:64]; end
      4'd4: begin
        w = {{32{a[31]}}, a[31:0]} * {{32{b[31]}}, b[31:0]};
        return {{32{w[31]}}, w[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Presents one op, returns the cycle (in_valid cycle = 0) where out_valid first rose.
  task automatic issue_and_wait(input logic [3:0] op, input logic [63:0] a,
                                input logic [63:0] b, input string name, output int lat);
    exp_q.push_back(model(op, a, b));
    src1 = a; src2 = b; control = op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    src1 = {$urandom, $urandom};
    src2 = {$urandom, $urandom};
    control = 4'($urandom_range(0, 15));
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s timeout: out_valid low after %0d cycles", name, lat);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int exp_lat, input string name);
    int lat;
    logic [63:0] exp;
    out_ready = 1'b1;
    issue_and_wait(op, a, b, name, lat);
    exp = exp_q.pop_front();
    checks++;
    if (result_out !== exp) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, result_out, exp);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    tick();
    expect_bit({name, " in_ready after handshake"}, in_ready, 1'b1);
    expect_bit({name, " out_valid after handshake"}, out_valid, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; control = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    expect_bit("reset in_ready", in_ready, 1'b1);
    expect_bit("reset out_valid", out_valid, 1'b0);
    checks++;
    if (result_out !== 64'd0) begin
      errors++;
      $display("FAIL reset result_out: got %h expected 0", result_out);
    end
  endtask

  task automatic test_ops();
    run_op(4'd0, 64'd3, 64'd5, 65, "mul_3x5");
    run_op(4'd1, '1, '1, 65, "mulh_m1xm1");
    run_op(4'd3, '1, '1, 65, "mulhu_max");
    run_op(4'd2, '1, 64'd2, 65, "mulhsu_m1x2");
    run_op(4'd4, 64'h7FFF_FFFF, 64'd2, 33, "mulw_max");
    run_op(4'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65, "mulh_minxmin");
    run_op(4'd0, 64'd0, 64'h1234_5678_9ABC_DEF0, 65, "mul_zero");
    run_op(4'd2, 64'h8000_0000_0000_0000, '1, 65, "mulhsu_minxmax");
    run_op(4'd4, 64'hDEAD_BEEF_8000_0000, 64'h0000_0000_FFFF_FFFF, 33, "mulw_hi_ignored");
    run_op(4'd7, 64'd9, 64'd9, 65, "invalid_op");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 4));
      run_op(op, {$urandom, $urandom}, {$urandom, $urandom}, (op == 4'd4) ? 33 : 65,
             "random");
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] exp;
    logic [63:0] held;
    out_ready = 1'b0;
    issue_and_wait(4'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd11, "hold", lat);
    exp = exp_q.pop_front();
    checks++;
    if (result_out !== exp) begin
      errors++;
      $display("FAIL hold result: got %h expected %h", result_out, exp);
    end
    held = exp;
    for (int i = 0; i < 10; i++) begin
      src1 = {$urandom, $urandom};
      tick();
      checks++;
      if (result_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: result %h valid %b ready %b, expected %h 1 0",
                 i, result_out, out_valid, in_ready, held);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    expect_bit("hold release in_ready", in_ready, 1'b1);
    expect_bit("hold release out_valid", out_valid, 1'b0);
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    out_ready = 1'b1;
    src1 = 64'd7; src2 = 64'd6; control = 4'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (44) begin
      tick();
      seen |= out_valid;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_bit("flush in_ready next cycle", in_ready, 1'b1);
    repeat (70) begin
      tick();
      seen |= out_valid;
    end
    expect_bit("flush no out_valid", seen, 1'b0);
    // Flush coinciding with in_valid must not accept the op.
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    seen = 1'b0;
    repeat (70) begin
      tick();
      seen |= out_valid;
    end
    expect_bit("flush with in_valid not accepted", seen, 1'b0);
    run_op(4'd3, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0003, 65, "after_flush");
  endtask

  task automatic test_reset_mid_busy();
    out_ready = 1'b1;
    src1 = 64'd2; src2 = 64'd3; control = 4'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    expect_bit("busy before reset in_ready", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_bit("mid-busy reset in_ready", in_ready, 1'b1);
    expect_bit("mid-busy reset out_valid", out_valid, 1'b0);
    checks++;
    if (result_out !== 64'd0) begin
      errors++;
      $display("FAIL mid-busy reset result_out: got %h expected 0", result_out);
    end
    run_op(4'd0, 64'd2, 64'd3, 65, "after_reset");
  endtask

  initial begin
    test_reset();
    test_ops();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
